// File: rtl/button_press_conditioner.sv
// button_press_conditioner: synchronise and debounce a push-button, emitting one press/release pulse per accepted edge
module button_press_conditioner #(
  parameter int SYNC_STAGES      = 2,
  parameter int DEBOUNCE_CYCLES  = 50000,
  parameter bit INPUT_ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic n_reset,
  input  logic button_raw,
  output logic button_press,
  output logic button_release,
  output logic button_level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [2:0] STARTUP      = 3'd0;
  localparam logic [2:0] STABLE_LOW   = 3'd1;
  localparam logic [2:0] CONFIRM_HIGH = 3'd2;
  localparam logic [2:0] STABLE_HIGH  = 3'd3;
  localparam logic [2:0] CONFIRM_LOW  = 3'd4;

  logic [SYNC_STAGES-1:0] sync;
  logic [2:0] state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic sync_in, done;

  assign sync_in = sync[SYNC_STAGES-1];
  // The final accepted sample hits when the stored count is one short; the counter is cleared on the transition
  assign done = cnt == CW'(DEBOUNCE_CYCLES - 1);

  always_comb begin
    state_n = state;
    cnt_n = '0;
    case (state)
      STARTUP:
        if (!sync_in) begin
          if (done) state_n = STABLE_LOW;
          else cnt_n = cnt + CW'(1);
        end
      STABLE_LOW:
        if (sync_in) begin
          state_n = CONFIRM_HIGH;
          cnt_n = CW'(1);
        end
      CONFIRM_HIGH:
        if (!sync_in) state_n = STABLE_LOW;
        else if (done) state_n = STABLE_HIGH;
        else cnt_n = cnt + CW'(1);
      STABLE_HIGH:
        if (!sync_in) begin
          state_n = CONFIRM_LOW;
          cnt_n = CW'(1);
        end
      CONFIRM_LOW:
        if (sync_in) state_n = STABLE_HIGH;
        else if (done) state_n = STABLE_LOW;
        else cnt_n = cnt + CW'(1);
      default: state_n = STARTUP;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync <= '0;
      state <= STARTUP;
      cnt <= '0;
      button_press <= 1'b0;
      button_release <= 1'b0;
      button_level <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], button_raw ^ INPUT_ACTIVE_LOW};
      state <= state_n;
      cnt <= cnt_n;
      button_press <= state == CONFIRM_HIGH && state_n == STABLE_HIGH;
      button_release <= state == CONFIRM_LOW && state_n == STABLE_LOW;
      button_level <= state_n == STABLE_HIGH || state_n == CONFIRM_LOW;
    end
  end
endmodule

// File: doc/button_press_conditioner.md
Name: button_press_conditioner

Overview:
- Upstream front end for the window open/close state machine.
- Takes the raw mechanical push-button pin, synchronises it to clk and debounces it.
- Emits a single-cycle button_press pulse per genuine press, so the downstream FSM toggles exactly once per physical press.
- Also provides the debounced level and a release pulse for status LEDs and test.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on button_raw; legal range 2..4.
- DEBOUNCE_CYCLES, 50000, consecutive identical synchronised samples required to accept a level change; legal minimum 2; counter width is $clog2(DEBOUNCE_CYCLES+1).
- INPUT_ACTIVE_LOW, 0, when 1, button_raw is inverted before the synchroniser (pressed = pin low).

Ports:
- clk  input  1  system clock.
- n_reset  input  1  asynchronous, active-low reset; asserts immediately, released synchronously to clk by the top level.
- button_raw  input  1  asynchronous pin from the switch; may bounce.
- button_press  output  1  registered single-cycle pulse on each accepted press; drives the window FSM button_press input.
- button_release  output  1  registered single-cycle pulse on each accepted release.
- button_level  output  1  registered debounced level (1 = pressed).

Behaviour:
- Polarity: the polarity-corrected input is button_raw XOR INPUT_ACTIVE_LOW. It passes through SYNC_STAGES flops to give sync_in. Nothing else samples button_raw.
- Reset values while n_reset=0:
  - all sync flops = 0 (not pressed);
  - counter = 0;
  - state = STARTUP;
  - button_press = button_release = button_level = 0.
- States:
  - STARTUP: counter counts consecutive sync_in=0 samples and clears on any sync_in=1. On reaching DEBOUNCE_CYCLES, go to STABLE_LOW and clear the counter. No pulses are produced in STARTUP. A button held through reset therefore never produces a press until it has been seen released.
  - STABLE_LOW: button_level=0. sync_in=1 moves to CONFIRM_HIGH with counter=1.
  - CONFIRM_HIGH:
    - Each cycle with sync_in=1 increments the counter.
    - When the counter reaches DEBOUNCE_CYCLES, go to STABLE_HIGH, set button_level=1 and pulse button_press for exactly one cycle.
    - Any sync_in=0 returns to STABLE_LOW, clears the counter and produces no pulse.
  - STABLE_HIGH: button_level=1. sync_in=0 moves to CONFIRM_LOW with counter=1.
  - CONFIRM_LOW: mirror of CONFIRM_HIGH.
    - Reaching DEBOUNCE_CYCLES goes to STABLE_LOW, sets button_level=0 and pulses button_release for exactly one cycle.
    - Any sync_in=1 returns to STABLE_HIGH with no pulse.
- Latency:
  - A clean rise sampled at edge E gives button_press high in the cycle following edge E+SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - Release latency is identical.
- Pulse rules:
  - button_press and button_release are never high simultaneously.
  - Each is never high for two consecutive cycles.
  - Holding the button indefinitely gives exactly one button_press.
- Counter saturation: the counter never exceeds DEBOUNCE_CYCLES and never wraps. It is cleared on every state change.
- Glitch rejection: any excursion shorter than DEBOUNCE_CYCLES synchronised samples is discarded with no output change.
- Reset mid-operation: an asynchronous n_reset assertion in any state forces all outputs to 0 on the same instant, including a pulse in flight, and returns to STARTUP.
- No X propagation: all outputs are driven from registers. Unreachable state encodings recover to STARTUP.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, INPUT_ACTIVE_LOW=0.
1. Startup:
   - Stimulus: release n_reset with button_raw=0, then raise button_raw at edge E and hold it for 20 cycles.
   - Required response: after 4 low samples the block is in STABLE_LOW; button_press=1 only in the cycle after edge E+5; button_level=1 thereafter; exactly one press pulse.
2. Bounce:
   - Stimulus: drive button_raw 1,0,1,1,0,1 (one cycle each), then hold 1.
   - Required response: no pulse during the bounce; a single button_press 4 clean samples after the last 0→1 transition.
3. Release:
   - Stimulus: from STABLE_HIGH, drop button_raw to 0 and hold.
   - Required response: button_release pulses once, 5 cycles after the sampling edge; button_level falls to 0 in the same cycle; button_press stays 0.
4. Held through reset:
   - Stimulus: keep button_raw=1 before, during and for 50 cycles after n_reset deassertion.
   - Required response: button_press stays 0 throughout. Then release, press again: exactly one button_press.
5. Mid-confirm reset:
   - Stimulus: assert n_reset while in CONFIRM_HIGH with counter=3.
   - Required response: outputs 0 immediately and no pulse follows after reset release until a full STARTUP plus a fresh press.
6. Inverted polarity:
   - Stimulus: with INPUT_ACTIVE_LOW=1, idle button_raw=1, then hold 0.
   - Required response: one button_press pulse at the same latency as scenario 1.
